// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
//   wb_state_e : FSM states of the stage (IDLE, WAIT_MEM)
//   ld_size_e  : load access size (byte, half, word, dword)
//   RF_WSEL_*  : writeback source select indices
package wb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_MEM
  } wb_state_e;

  typedef enum logic [1:0] {
    LD_B,
    LD_H,
    LD_W,
    LD_D
  } ld_size_e;

  localparam int unsigned RF_WSEL_ALUC = 0;
  localparam int unsigned RF_WSEL_DBUS = 1;
  localparam int unsigned RF_WSEL_PC4  = 2;
  localparam int unsigned RF_WSEL_SEXT = 3;
  localparam int unsigned RF_WSEL_CSR  = 4;

endpackage

// File: rtl/wb_stage_unit_if.sv
// Writeback stage bus bundle: retire handshake, data-bus response and regfile write port.
//   master : upstream/environment side (drives in_*, dbus_*; observes in_ready, rf_*)
//   slave  : writeback stage side
interface wb_stage_unit_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NSRC   = 5,
  parameter int unsigned WSEL_W = 3,
  parameter int unsigned RA_W   = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WSEL_W-1:0]    in_wsel;
  logic                 in_wen;
  logic [RA_W-1:0]      in_rd;
  logic [NSRC*XLEN-1:0] in_src;
  logic [1:0]           in_ld_size;
  logic                 in_ld_uns;
  logic [2:0]           in_addr_lo;
  logic                 dbus_rvalid;
  logic [XLEN-1:0]      dbus_rdata;
  logic                 rf_we;
  logic [RA_W-1:0]      rf_wa;
  logic [XLEN-1:0]      rf_wd;

  modport master (
    output in_valid, in_wsel, in_wen, in_rd, in_src, in_ld_size, in_ld_uns, in_addr_lo,
    output dbus_rvalid, dbus_rdata,
    input  in_ready, rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  in_valid, in_wsel, in_wen, in_rd, in_src, in_ld_size, in_ld_uns, in_addr_lo,
    input  dbus_rvalid, dbus_rdata,
    output in_ready, rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/wb_load_ext.sv
// Load data alignment and extension (combinational).
//   rdata   : raw dword from the data bus
//   addr_lo : byte offset within the dword; bytes shifted in from above bit XLEN-1 read as 0
//   size    : access size
//   uns     : 1 = zero-extend, 0 = sign-extend
//   data    : aligned, extended result
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      addr_lo,
  input  ld_size_e        size,
  input  logic            uns,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;
  logic            msb;
  int unsigned     width;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    width = XLEN;
    unique case (size)
      LD_B:    width = 8;
      LD_H:    width = 16;
      LD_W:    width = 32;
      LD_D:    width = 64;
      default: width = XLEN;
    endcase
    if (width > XLEN) width = XLEN;

    msb = 1'b0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (i == width - 1) msb = shifted[i];
    end

    data = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      data[i] = (i < width) ? shifted[i] : (~uns & msb);
    end
  end

endmodule

// File: rtl/wb_stage_unit.sv
// Writeback stage: selects a source (or waits for load data), then issues one registered
// regfile write that also serves as the decode forwarding source.
//   clk, reset  : clock; synchronous active-low reset
//   bus         : retire handshake, dbus response, regfile write port (slave side)
//   err_timeout : sticky flag, set when a load gets no response within TIMEOUT cycles
module wb_stage_unit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NSRC     = 5,
  parameter int unsigned WSEL_W   = 3,
  parameter int unsigned DBUS_IDX = RF_WSEL_DBUS,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             reset,
  wb_stage_unit_if.slave   bus,
  output logic             err_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  wb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RA_W-1:0] ld_rd_q;
  logic            ld_wen_q;
  ld_size_e        ld_size_q;
  logic            ld_uns_q;
  logic [2:0]      ld_addr_q;
  logic            ld_latch;
  logic            we_q, we_d;
  logic [RA_W-1:0] wa_q, wa_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] src_sel;
  logic [XLEN-1:0] ld_data;
  logic            is_load;

  wb_load_ext #(
    .XLEN (XLEN)
  ) u_load_ext (
    .rdata   (bus.dbus_rdata),
    .addr_lo (ld_addr_q),
    .size    (ld_size_q),
    .uns     (ld_uns_q),
    .data    (ld_data)
  );

  // Out-of-range selects fall through to zero.
  always_comb begin
    src_sel = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (32'(bus.in_wsel) == i) src_sel = bus.in_src[i*XLEN +: XLEN];
    end
  end

  assign is_load = (32'(bus.in_wsel) == DBUS_IDX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_latch = 1'b0;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_load) begin
            ld_latch = 1'b1;
            cnt_d    = '0;
            state_d  = WAIT_MEM;
          end else if (bus.in_wen && (bus.in_rd != '0)) begin
            we_d = 1'b1;
            wa_d = bus.in_rd;
            wd_d = src_sel;
          end
        end
      end
      WAIT_MEM: begin
        if (bus.dbus_rvalid) begin
          state_d = IDLE;
          if (ld_wen_q && (ld_rd_q != '0)) begin
            we_d = 1'b1;
            wa_d = ld_rd_q;
            wd_d = ld_data;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= '0;
      ld_wen_q  <= 1'b0;
      ld_size_q <= LD_B;
      ld_uns_q  <= 1'b0;
      ld_addr_q <= '0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      if (ld_latch) begin
        ld_rd_q   <= bus.in_rd;
        ld_wen_q  <= bus.in_wen;
        ld_size_q <= ld_size_e'(bus.in_ld_size);
        ld_uns_q  <= bus.in_ld_uns;
        ld_addr_q <= bus.in_addr_lo;
      end
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.rf_we    = we_q;
  assign bus.rf_wa    = wa_q;
  assign bus.rf_wd    = wd_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_wb_stage_unit.sv
module tb_wb_stage_unit;
  import wb_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NSRC = 5;
  localparam int unsigned TOUT = 16;

  typedef struct packed {
    logic [4:0]  wa;
    logic [63:0] wd;
  } exp_t;

  logic clk;
  logic reset;
  logic err_timeout;
  int   checks;
  int   failures;
  exp_t sb[$];

  wb_stage_unit_if #(.XLEN(XLEN), .NSRC(NSRC), .WSEL_W(3), .RA_W(5)) bus ();

  wb_stage_unit #(
    .XLEN     (XLEN),
    .NSRC     (NSRC),
    .WSEL_W   (3),
    .DBUS_IDX (1),
    .RA_W     (5),
    .TIMEOUT  (TOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && bus.rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_we", {63'd0, bus.rf_we}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rf_wa", {59'd0, bus.rf_wa}, {59'd0, e.wa});
        check("rf_wd", bus.rf_wd, e.wd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a non-load retire for one cycle; slot i holds base + i.
  task automatic retire(input int unsigned wsel, input logic [4:0] rd, input logic wen,
                        input logic [63:0] base);
    logic [63:0] expv;
    bus.in_valid = 1'b1;
    bus.in_wsel  = 3'(wsel);
    bus.in_rd    = rd;
    bus.in_wen   = wen;
    for (int i = 0; i < NSRC; i++) bus.in_src[i*XLEN +: XLEN] = base + 64'(i);
    expv = (wsel < NSRC) ? base + 64'(wsel) : 64'd0;
    if (wen && rd != 5'd0) sb.push_back('{wa: rd, wd: expv});
    tick();
  endtask

  task automatic accept_load(input logic [4:0] rd, input logic [1:0] size, input logic uns,
                             input logic [2:0] lo);
    bus.in_valid   = 1'b1;
    bus.in_wsel    = 3'(RF_WSEL_DBUS);
    bus.in_rd      = rd;
    bus.in_wen     = 1'b1;
    bus.in_ld_size = size;
    bus.in_ld_uns  = uns;
    bus.in_addr_lo = lo;
    // Response in the accept cycle must be ignored.
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.in_valid    = 1'b0;
    bus.dbus_rvalid = 1'b0;
  endtask

  task automatic respond(input logic [63:0] rdata, input logic [4:0] rd, input logic [63:0] expv);
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = rdata;
    sb.push_back('{wa: rd, wd: expv});
    tick();
    bus.dbus_rvalid = 1'b0;
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    bus.in_valid = 1'b0; bus.in_wsel = '0; bus.in_wen = 1'b0; bus.in_rd = '0;
    bus.in_src = '0; bus.in_ld_size = '0; bus.in_ld_uns = 1'b0; bus.in_addr_lo = '0;
    bus.dbus_rvalid = 1'b0; bus.dbus_rdata = '0;
    reset = 1'b0;
    tick(); tick();
    check("rst_we", {63'd0, bus.rf_we}, 64'd0);
    check("rst_wa", {59'd0, bus.rf_wa}, 64'd0);
    check("rst_wd", bus.rf_wd, 64'd0);
    check("rst_err", {63'd0, err_timeout}, 64'd0);
    check("rst_ready", {63'd0, bus.in_ready}, 64'd1);
    reset = 1'b1;
    tick();

    // ALU writeback, latency 1
    bus.in_valid = 1'b1; bus.in_wsel = 3'(RF_WSEL_ALUC); bus.in_rd = 5'd5; bus.in_wen = 1'b1;
    bus.in_src = '0; bus.in_src[63:0] = 64'h1234;
    sb.push_back('{wa: 5'd5, wd: 64'h1234});
    tick();
    bus.in_valid = 1'b0;
    check("alu_ready", {63'd0, bus.in_ready}, 64'd1);
    check("alu_we", {63'd0, bus.rf_we}, 64'd1);
    tick();

    // LB signed, offset 3, response two cycles after accept
    accept_load(5'd7, 2'd0, 1'b0, 3'd3);
    check("lb_wait_ready", {63'd0, bus.in_ready}, 64'd0);
    tick();
    check("lb_wait_ready2", {63'd0, bus.in_ready}, 64'd0);
    respond(64'h0000_0000_8000_0000, 5'd7, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_ready_after", {63'd0, bus.in_ready}, 64'd1);
    tick();

    // LHU offset 6
    accept_load(5'd8, 2'd1, 1'b1, 3'd6);
    respond(64'hBEEF_0000_0000_0000, 5'd8, 64'h0000_0000_0000_BEEF);
    tick();
    // LW signed crossing the dword: upper bytes read as zero, so result stays positive
    accept_load(5'd11, 2'd2, 1'b0, 3'd6);
    respond(64'h8123_4567_89AB_CDEF, 5'd11, 64'h0000_0000_0000_8123);
    // LD at offset 0, back-to-back with the previous load
    accept_load(5'd12, 2'd3, 1'b0, 3'd0);
    respond(64'hF00D_CAFE_1234_5678, 5'd12, 64'hF00D_CAFE_1234_5678);
    // LH signed at offset 2
    accept_load(5'd13, 2'd1, 1'b0, 3'd2);
    respond(64'h0000_0000_9ABC_0000, 5'd13, 64'hFFFF_FFFF_FFFF_9ABC);
    tick();

    // Back-to-back PC4 / SEXT, then rd=0, wen=0 and out-of-range select
    retire(RF_WSEL_PC4, 5'd1, 1'b1, 64'hA000_0000_0000_0000);
    check("b2b_ready", {63'd0, bus.in_ready}, 64'd1);
    retire(RF_WSEL_SEXT, 5'd2, 1'b1, 64'h0000_0000_5555_0000);
    check("b2b_we2", {63'd0, bus.rf_we}, 64'd1);
    retire(RF_WSEL_CSR, 5'd0, 1'b1, 64'h1111);
    check("rd0_no_we", {63'd0, bus.rf_we}, 64'd0);
    retire(RF_WSEL_ALUC, 5'd4, 1'b0, 64'h2222);
    retire(6, 5'd3, 1'b1, 64'h3333);
    bus.in_valid = 1'b0;
    tick();

    // Response while idle is ignored
    bus.dbus_rvalid = 1'b1; bus.dbus_rdata = 64'h77;
    tick();
    bus.dbus_rvalid = 1'b0;
    tick();

    // Timeout
    accept_load(5'd9, 2'd3, 1'b0, 3'd0);
    n = 1;
    while (err_timeout !== 1'b1 && n < 40) begin
      tick();
      if (err_timeout !== 1'b1) n++;
    end
    check("timeout_cycles", 64'(n), 64'(TOUT));
    check("timeout_err", {63'd0, err_timeout}, 64'd1);
    check("timeout_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.dbus_rvalid = 1'b1; bus.dbus_rdata = 64'h99;
    tick();
    bus.dbus_rvalid = 1'b0;
    tick();
    check("timeout_sticky", {63'd0, err_timeout}, 64'd1);

    // Reset during WAIT_MEM discards the pending load
    accept_load(5'd10, 2'd3, 1'b0, 3'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.dbus_rvalid = 1'b1; bus.dbus_rdata = 64'hDEAD;
    tick();
    bus.dbus_rvalid = 1'b0;
    tick();
    check("rstw_we", {63'd0, bus.rf_we}, 64'd0);
    check("rstw_wa", {59'd0, bus.rf_wa}, 64'd0);
    check("rstw_wd", bus.rf_wd, 64'd0);
    check("rstw_err", {63'd0, err_timeout}, 64'd0);
    check("rstw_ready", {63'd0, bus.in_ready}, 64'd1);

    tick(); tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
